// File: rtl/rca_exec_unit.sv
// RCA execution unit: config/use ops over valid/ready issue, programmable latency,
// operand routing via result-select table, completions queued to a valid/ack writeback FIFO.
module rca_exec_unit #(
  parameter int XLEN            = 32,
  parameter int NUM_RCAS        = 3,
  parameter int NUM_READ_PORTS  = 5,
  parameter int NUM_WRITE_PORTS = 5,
  parameter int ID_W            = 3,
  parameter int MAX_LAT         = 15,
  parameter int FIFO_DEPTH      = 4,
  localparam int RCA_W  = (NUM_RCAS > 1) ? $clog2(NUM_RCAS) : 1,
  localparam int PORT_W = (NUM_WRITE_PORTS > 1) ? $clog2(NUM_WRITE_PORTS) : 1,
  localparam int CFG_W  = $clog2(MAX_LAT + 1),
  localparam int RSEL_W = (NUM_READ_PORTS > 1) ? $clog2(NUM_READ_PORTS) : 1,
  localparam int PTR_W  = $clog2(FIFO_DEPTH),
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            issue_valid,
  output logic                            issue_ready,
  input  logic [ID_W-1:0]                 issue_id,
  input  logic [1:0]                      issue_op,
  input  logic [RCA_W-1:0]                issue_rca_sel,
  input  logic [PORT_W-1:0]               issue_port,
  input  logic [CFG_W-1:0]                issue_cfg_data,
  input  logic [NUM_READ_PORTS*XLEN-1:0]  issue_rs,
  output logic                            wb_valid,
  input  logic                            wb_ack,
  output logic [ID_W-1:0]                 wb_id,
  output logic [NUM_WRITE_PORTS*XLEN-1:0] wb_rd,
  output logic                            busy
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EXEC = 1'b1;

  typedef logic [NUM_WRITE_PORTS-1:0][RSEL_W-1:0] sel_row_t;

  logic [0:0]                          state;
  logic [CFG_W-1:0]                    lat_cnt;
  logic [ID_W-1:0]                     ex_id;
  logic [NUM_READ_PORTS-1:0][XLEN-1:0] ex_rs;
  sel_row_t                            ex_sel;
  logic                                ex_kill;

  sel_row_t         result_sel [NUM_RCAS];
  logic [CFG_W-1:0] latency    [NUM_RCAS];

  logic [NUM_WRITE_PORTS*XLEN-1:0] mem_rd [FIFO_DEPTH];
  logic [ID_W-1:0]                 mem_id [FIFO_DEPTH];
  logic [PTR_W-1:0]                wr_ptr;
  logic [PTR_W-1:0]                rd_ptr;
  logic [CNT_W-1:0]                count;

  logic                                 accept;
  logic                                 rca_ok;
  logic                                 port_ok;
  logic [CFG_W-1:0]                     lat_new;
  logic [RSEL_W-1:0]                    sel_new;
  logic [NUM_WRITE_PORTS-1:0][XLEN-1:0] use_rd;
  logic                                 push_use;
  logic                                 push_cfg;
  logic                                 push;
  logic                                 pop;
  logic [ID_W-1:0]                      push_id;
  logic [NUM_WRITE_PORTS*XLEN-1:0]      push_rd;

  assign issue_ready = (state == S_IDLE) && (count < CNT_W'(FIFO_DEPTH));
  assign accept      = issue_valid && issue_ready;
  assign rca_ok      = 32'(issue_rca_sel) < NUM_RCAS;
  assign port_ok     = 32'(issue_port) < NUM_WRITE_PORTS;
  assign sel_new     = RSEL_W'(32'(issue_cfg_data) % 32'(NUM_READ_PORTS));

  always_comb begin
    lat_new = issue_cfg_data;
    if (issue_cfg_data == '0)
      lat_new = CFG_W'(1);
    else if (32'(issue_cfg_data) > MAX_LAT)
      lat_new = CFG_W'(MAX_LAT);
  end

  always_comb begin
    use_rd = '0;
    for (int w = 0; w < NUM_WRITE_PORTS; w++)
      use_rd[w] = ex_rs[ex_sel[w]];
    if (ex_kill)
      use_rd = '0;
  end

  // Pushes from config ops happen only while IDLE, use pushes only in EXEC,
  // so the two sources never collide.
  assign push_use = (state == S_EXEC) && (lat_cnt == '0);
  assign push_cfg = accept && (issue_op != 2'd0);
  assign push     = push_use || push_cfg;
  assign pop      = wb_valid && wb_ack;
  assign push_id  = push_use ? ex_id : issue_id;
  assign push_rd  = push_use ? use_rd : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      lat_cnt <= '0;
      ex_id   <= '0;
      ex_rs   <= '0;
      ex_sel  <= '0;
      ex_kill <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      for (int r = 0; r < NUM_RCAS; r++) begin
        latency[r] <= CFG_W'(1);
        for (int w = 0; w < NUM_WRITE_PORTS; w++)
          result_sel[r][w] <= (w < NUM_READ_PORTS) ?
                              RSEL_W'(NUM_READ_PORTS - 1 - w) : '0;
      end
    end else begin
      if (accept) begin
        unique case (issue_op)
          2'd0: begin
            state   <= S_EXEC;
            ex_id   <= issue_id;
            ex_rs   <= issue_rs;
            ex_kill <= !rca_ok;
            ex_sel  <= rca_ok ? result_sel[issue_rca_sel] : '0;
            lat_cnt <= rca_ok ? latency[issue_rca_sel] - CFG_W'(1) : '0;
          end
          2'd1: begin
            if (rca_ok && port_ok)
              result_sel[issue_rca_sel][issue_port] <= sel_new;
          end
          2'd2: begin
            if (rca_ok)
              latency[issue_rca_sel] <= lat_new;
          end
          2'd3: ;
        endcase
      end else if (state == S_EXEC) begin
        if (lat_cnt == '0)
          state <= S_IDLE;
        else
          lat_cnt <= lat_cnt - CFG_W'(1);
      end
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_id[wr_ptr] <= push_id;
      mem_rd[wr_ptr] <= push_rd;
    end
  end

  assign wb_valid = (count != '0);
  assign wb_id    = wb_valid ? mem_id[rd_ptr] : '0;
  assign wb_rd    = wb_valid ? mem_rd[rd_ptr] : '0;
  assign busy     = (state == S_EXEC) || wb_valid;

endmodule

// File: tb/tb_rca_exec_unit.sv
// Directed self-checking bench for rca_exec_unit with default parameters.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_rca_exec_unit;

  logic         clk;
  logic         rst;
  logic         issue_valid;
  logic         issue_ready;
  logic [2:0]   issue_id;
  logic [1:0]   issue_op;
  logic [1:0]   issue_rca_sel;
  logic [2:0]   issue_port;
  logic [3:0]   issue_cfg_data;
  logic [159:0] issue_rs;
  logic         wb_valid;
  logic         wb_ack;
  logic [2:0]   wb_id;
  logic [159:0] wb_rd;
  logic         busy;

  int checks;
  int errors;
  logic stale;

  rca_exec_unit dut (
    .clk            (clk),
    .rst            (rst),
    .issue_valid    (issue_valid),
    .issue_ready    (issue_ready),
    .issue_id       (issue_id),
    .issue_op       (issue_op),
    .issue_rca_sel  (issue_rca_sel),
    .issue_port     (issue_port),
    .issue_cfg_data (issue_cfg_data),
    .issue_rs       (issue_rs),
    .wb_valid       (wb_valid),
    .wb_ack         (wb_ack),
    .wb_id          (wb_id),
    .wb_rd          (wb_rd),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [159:0] rs5(input int a4, input int a3,
                                       input int a2, input int a1,
                                       input int a0);
    return {32'(a4), 32'(a3), 32'(a2), 32'(a1), 32'(a0)};
  endfunction

  task automatic chk(input string tag, input logic [159:0] obs,
                     input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [1:0] rca,
                       input logic [2:0] port, input logic [3:0] cfg,
                       input logic [2:0] id, input logic [159:0] rs);
    issue_op       = op;
    issue_rca_sel  = rca;
    issue_port     = port;
    issue_cfg_data = cfg;
    issue_id       = id;
    issue_rs       = rs;
    issue_valid    = 1'b1;
    chk("issue_ready_pre", 160'(issue_ready), 160'(1));
    step();
    issue_valid = 1'b0;
    issue_op    = 2'd3;
  endtask

  task automatic pop();
    wb_ack = 1'b1;
    step();
    wb_ack = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    stale  = 1'b0;
    rst            = 1'b1;
    issue_valid    = 1'b0;
    issue_id       = '0;
    issue_op       = 2'd3;
    issue_rca_sel  = '0;
    issue_port     = '0;
    issue_cfg_data = '0;
    issue_rs       = '0;
    wb_ack         = 1'b0;
    repeat (2) step();
    chk("rst_wb_valid", 160'(wb_valid), 160'(0));
    chk("rst_busy", 160'(busy), 160'(0));
    chk("rst_wb_id", 160'(wb_id), 160'(0));
    chk("rst_wb_rd", wb_rd, 160'(0));
    chk("rst_ready", 160'(issue_ready), 160'(1));
    rst = 1'b0;
    step();

    issue(2'd0, 2'd0, 3'd0, 4'd0, 3'd2, rs5(5, 4, 3, 2, 1));
    chk("use1_busy", 160'(busy), 160'(1));
    chk("use1_ready_exec", 160'(issue_ready), 160'(0));
    chk("use1_not_yet", 160'(wb_valid), 160'(0));
    step();
    chk("use1_valid", 160'(wb_valid), 160'(1));
    chk("use1_id", 160'(wb_id), 160'(2));
    chk("use1_rd", wb_rd, rs5(1, 2, 3, 4, 5));
    chk("use1_ready_back", 160'(issue_ready), 160'(1));
    pop();
    chk("use1_popped", 160'(wb_valid), 160'(0));
    chk("use1_idle", 160'(busy), 160'(0));

    issue(2'd2, 2'd1, 3'd0, 4'd4, 3'd3, '0);
    chk("cfglat_valid", 160'(wb_valid), 160'(1));
    chk("cfglat_id", 160'(wb_id), 160'(3));
    chk("cfglat_rd", wb_rd, 160'(0));
    pop();
    wb_ack = 1'b1;
    issue(2'd0, 2'd1, 3'd0, 4'd0, 3'd4, rs5(50, 40, 30, 20, 10));
    for (int i = 0; i < 4; i++) begin
      chk("lat4_ready", 160'(issue_ready), 160'(0));
      chk("lat4_early", 160'(wb_valid), 160'(0));
      step();
    end
    chk("lat4_valid", 160'(wb_valid), 160'(1));
    chk("lat4_id", 160'(wb_id), 160'(4));
    chk("lat4_rd", wb_rd, rs5(10, 20, 30, 40, 50));
    chk("lat4_ready_back", 160'(issue_ready), 160'(1));
    step();
    wb_ack = 1'b0;
    chk("lat4_drained", 160'(wb_valid), 160'(0));

    issue(2'd2, 2'd0, 3'd0, 4'd3, 3'd5, '0);
    pop();
    issue(2'd2, 2'd0, 3'd0, 4'd0, 3'd6, '0);
    chk("lat0_id", 160'(wb_id), 160'(6));
    chk("lat0_rd", wb_rd, 160'(0));
    pop();
    issue(2'd1, 2'd0, 3'd3, 4'd0, 3'd7, '0);
    chk("sel_id", 160'(wb_id), 160'(7));
    pop();
    issue(2'd1, 2'd0, 3'd2, 4'd8, 3'd0, '0);
    pop();
    issue(2'd0, 2'd0, 3'd0, 4'd0, 3'd1, rs5(5, 4, 3, 2, 1));
    chk("sel_use_early", 160'(wb_valid), 160'(0));
    step();
    chk("sel_use_lat1", 160'(wb_valid), 160'(1));
    chk("sel_use_id", 160'(wb_id), 160'(1));
    chk("sel_use_rd", wb_rd, rs5(1, 1, 4, 4, 5));
    pop();

    for (int i = 0; i < 4; i++)
      issue(2'd3, 2'd0, 3'd0, 4'd0, 3'(i), '0);
    chk("full_ready", 160'(issue_ready), 160'(0));
    chk("full_busy", 160'(busy), 160'(1));
    chk("full_head", 160'(wb_id), 160'(0));
    pop();
    chk("pop1_head", 160'(wb_id), 160'(1));
    chk("pop1_ready", 160'(issue_ready), 160'(1));
    pop();
    chk("pop2_head", 160'(wb_id), 160'(2));
    wb_ack = 1'b1;
    issue(2'd3, 2'd0, 3'd0, 4'd0, 3'd6, '0);
    wb_ack = 1'b0;
    chk("pushpop_head", 160'(wb_id), 160'(3));
    pop();
    chk("pushpop_tail", 160'(wb_id), 160'(6));
    pop();
    chk("fifo_empty", 160'(wb_valid), 160'(0));

    issue(2'd2, 2'd2, 3'd0, 4'd10, 3'd1, '0);
    pop();
    issue(2'd0, 2'd2, 3'd0, 4'd0, 3'd2, rs5(9, 9, 9, 9, 9));
    repeat (3) step();
    chk("exec10_busy", 160'(busy), 160'(1));
    chk("exec10_pending", 160'(wb_valid), 160'(0));
    rst = 1'b1;
    #1;
    chk("midrst_valid", 160'(wb_valid), 160'(0));
    chk("midrst_busy", 160'(busy), 160'(0));
    chk("midrst_ready", 160'(issue_ready), 160'(1));
    step();
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (wb_valid)
        stale = 1'b1;
    end
    chk("no_stale", 160'(stale), 160'(0));

    issue(2'd2, 2'd3, 3'd0, 4'd5, 3'd3, '0);
    chk("oor_cfg_valid", 160'(wb_valid), 160'(1));
    chk("oor_cfg_id", 160'(wb_id), 160'(3));
    pop();
    issue(2'd1, 2'd3, 3'd0, 4'd2, 3'd4, '0);
    pop();
    issue(2'd0, 2'd3, 3'd0, 4'd0, 3'd5, rs5(5, 4, 3, 2, 1));
    chk("oor_use_early", 160'(wb_valid), 160'(0));
    step();
    chk("oor_use_valid", 160'(wb_valid), 160'(1));
    chk("oor_use_id", 160'(wb_id), 160'(5));
    chk("oor_use_rd", wb_rd, 160'(0));
    pop();
    issue(2'd0, 2'd0, 3'd0, 4'd0, 3'd6, rs5(5, 4, 3, 2, 1));
    step();
    chk("dflt_valid", 160'(wb_valid), 160'(1));
    chk("dflt_rd", wb_rd, rs5(1, 2, 3, 4, 5));
    pop();
    chk("final_idle", 160'(busy), 160'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rca_exec_unit.md
Name: rca_exec_unit

Overview:
- Parametrised successor to the single-slot RCA stub. Accepts issued RCA instructions (use, result-routing config, latency config) over a valid/ready handshake.
- Executes "use" ops with a per-RCA programmable latency, routing read-port operands to write ports through per-RCA configurable result-select registers.
- Queues completions in a result FIFO drained by a valid/ack writeback port.
- Sits between the issue stage and the multi-port RCA writeback path.

Parameters:
- XLEN, 32, operand/result width.
- NUM_RCAS, 3, number of RCA configurations held.
- NUM_READ_PORTS, 5, source operands per use op.
- NUM_WRITE_PORTS, 5, results per completion.
- ID_W, 3, instruction id width.
- MAX_LAT, 15, maximum programmable latency in cycles.
- FIFO_DEPTH, 4, result FIFO entries (power of two, >=2).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- issue_valid  in  1  request present.
- issue_ready  out  1  unit can accept.
- issue_id  in  ID_W  instruction id.
- issue_op  in  2  0=use, 1=cfg_result_sel, 2=cfg_latency, 3=nop.
- issue_rca_sel  in  clog2(NUM_RCAS)  target RCA.
- issue_port  in  clog2(NUM_WRITE_PORTS)  write port for cfg_result_sel.
- issue_cfg_data  in  clog2(MAX_LAT+1)  new read-port select or latency value.
- issue_rs  in  NUM_READ_PORTS*XLEN  operands; port k at bits [k*XLEN +: XLEN].
- wb_valid  out  1  FIFO head valid.
- wb_ack  in  1  consumer accepts head.
- wb_id  out  ID_W  head id.
- wb_rd  out  NUM_WRITE_PORTS*XLEN  head results, same packing as issue_rs.
- busy  out  1  op executing or FIFO non-empty.

Behaviour:
- Reset (async, immediate):
  - State=IDLE; FIFO pointers and count=0; wb_valid=0, wb_id=0, wb_rd=0, busy=0.
  - result_sel[r][w] = NUM_READ_PORTS-1-w if w<NUM_READ_PORTS, else 0.
  - latency[r]=1.
  - Reset mid-EXEC discards the op; nothing is pushed.
- Handshake:
  - Accept when issue_valid && issue_ready.
  - issue_ready = (state==IDLE) && (count<FIFO_DEPTH).
- Config ops (1, 2):
  - Apply at the accept edge.
  - cfg_result_sel writes result_sel[rca][port] = cfg_data mod NUM_READ_PORTS.
  - cfg_latency writes latency[rca] = clamp(cfg_data, 1, MAX_LAT); 0 becomes 1.
  - Out-of-range rca_sel or port: the write is ignored.
  - In all cases (including nop), push {id, rd=0} into the FIFO at the same edge; state stays IDLE.
- Use op (0):
  - At accept, capture id, operands, the RCA's result_sel row and latency L. Later config writes do not affect an in-flight op.
  - State IDLE->EXEC, counter=L-1.
  - If L==1, push at the next edge; otherwise decrement each cycle and push when the counter reaches 0.
  - The push cycle returns state to IDLE, giving exactly L cycles from accept edge to push edge.
  - Result: rd[w] = rs[sel[w]].
  - Out-of-range rca_sel: all rd=0, L=1.
- FIFO:
  - Head is registered storage; wb_valid = count!=0.
  - Pop on wb_valid && wb_ack.
  - Simultaneous push and pop: count unchanged, order preserved.
  - Pointers wrap modulo FIFO_DEPTH.
  - Push never occurs when full, because ready gating reserves the slot at accept.
  - wb_ack while empty is ignored.
- busy = (state==EXEC) || (count!=0).

Test Plan:
- Reset, then use op with id=2 and rs = {5,4,3,2,1} (port 0 = 1) -> one cycle later wb_valid=1, wb_id=2, rd = {1,2,3,4,5} (port 0 = 5); ack pops it and busy drops to 0.
- cfg_latency rca=1, data=4, then use rca=1 with wb_ack=1 held -> issue_ready=0 for 4 cycles; push exactly 4 edges after accept.
- cfg_latency data=0 -> latency 1. cfg_result_sel rca=0, port=3, data=0, then use -> rd[3]=rs[0]. Each config op produces a done entry with rd=0.
- Hold wb_ack=0 and issue 4 nops -> count=4 and issue_ready=0. Assert ack for one cycle -> FIFO order preserved; issue_ready=1 the next cycle.
- Pulse rst while in EXEC with L=10 -> immediately state=IDLE, wb_valid=0, busy=0; no stale completion appears.
- Out-of-range rca_sel=3 (NUM_RCAS=3) on a config op and a use op -> config unchanged; use completes after 1 cycle with rd all 0.
